// File: rtl/cva5_types.sv
// Core-wide shared type definitions: the exception cause field width.
package cva5_types;

    localparam int ECODE_W = 5;

endpackage

// File: rtl/riscv_types.sv
// RISC-V architectural constants used by the decode exception path.
package riscv_types;

    localparam logic [4:0] ILLEGAL_INST    = 5'd2;
    localparam logic [4:0] INST_PAGE_FAULT = 5'd12;

endpackage

// File: rtl/decode_exception_sequencer.sv
// Decode-stage exception sequencer.
// Sequence for an illegal encoding or a fetch page fault:
//   1. Block issue of the faulting instruction.
//   2. Wait for issued work to drain.
//   3. Hold one request to the exception gateway.
//   4. Keep issue blocked until the front-end flush that follows the trap.
module decode_exception_sequencer
    import cva5_types::*;
    import riscv_types::*;
#(
    parameter int ID_WIDTH = 3,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                decode_valid,
    input  logic [31:0]         decode_instruction,
    input  logic [31:0]         decode_pc,
    input  logic [ID_WIDTH-1:0] decode_id,
    input  logic                decode_illegal,
    input  logic                decode_fetch_fault,
    input  logic                pipeline_empty,
    input  logic                flush,
    output logic                issue_block,
    output logic                exception_valid,
    output logic [ECODE_W-1:0]  exception_code,
    output logic [31:0]         exception_pc,
    output logic [31:0]         exception_tval,
    output logic [ID_WIDTH-1:0] exception_id,
    input  logic                exception_ack,
    output logic [COUNT_W-1:0]  illegal_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        REQUEST,
        WAIT_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [ECODE_W-1:0]  code_q, code_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         tval_q, tval_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                trigger;

    // A flush in the same cycle kills the decode instruction, so it cannot fault.
    assign trigger = decode_valid & (decode_illegal | decode_fetch_fault) & ~flush;

    // Next-state, capture and counter logic.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        id_d    = id_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    pc_d = decode_pc;
                    id_d = decode_id;
                    // Fetch faults win: the instruction bits are not trustworthy.
                    if (decode_fetch_fault) begin
                        code_d = INST_PAGE_FAULT;
                        tval_d = decode_pc;
                    end else begin
                        code_d = ILLEGAL_INST;
                        tval_d = decode_instruction;
                    end
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (pipeline_empty) begin
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                // Ack beats a coincident flush: the gateway already took the trap.
                if (exception_ack) begin
                    state_d = WAIT_FLUSH;
                    if ((code_q == ILLEGAL_INST) && (count_q != {COUNT_W{1'b1}})) begin
                        count_d = count_q + COUNT_W'(1);
                    end
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT_FLUSH: begin
                if (flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured exception fields and event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
            id_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            id_q    <= id_d;
            count_q <= count_d;
        end
    end

    assign issue_block     = (state_q != IDLE) | trigger;
    assign exception_valid = (state_q == REQUEST);
    assign exception_code  = code_q;
    assign exception_pc    = pc_q;
    assign exception_tval  = tval_q;
    assign exception_id    = id_q;
    assign illegal_count   = count_q;

endmodule

// File: tb/tb_decode_exception_sequencer.sv
// Directed self-checking bench for decode_exception_sequencer (COUNT_W=4 build).
module tb_decode_exception_sequencer;

    localparam int ID_WIDTH = 3;
    localparam int COUNT_W  = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                decode_valid;
    logic [31:0]         decode_instruction;
    logic [31:0]         decode_pc;
    logic [ID_WIDTH-1:0] decode_id;
    logic                decode_illegal;
    logic                decode_fetch_fault;
    logic                pipeline_empty;
    logic                flush;
    logic                issue_block;
    logic                exception_valid;
    logic [4:0]          exception_code;
    logic [31:0]         exception_pc;
    logic [31:0]         exception_tval;
    logic [ID_WIDTH-1:0] exception_id;
    logic                exception_ack;
    logic [COUNT_W-1:0]  illegal_count;

    int checks = 0;
    int errors = 0;

    decode_exception_sequencer #(.ID_WIDTH(ID_WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .decode_valid(decode_valid),
        .decode_instruction(decode_instruction),
        .decode_pc(decode_pc),
        .decode_id(decode_id),
        .decode_illegal(decode_illegal),
        .decode_fetch_fault(decode_fetch_fault),
        .pipeline_empty(pipeline_empty),
        .flush(flush),
        .issue_block(issue_block),
        .exception_valid(exception_valid),
        .exception_code(exception_code),
        .exception_pc(exception_pc),
        .exception_tval(exception_tval),
        .exception_id(exception_id),
        .exception_ack(exception_ack),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ill, input logic ff, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [ID_WIDTH-1:0] id);
        decode_valid       = 1'b1;
        decode_illegal     = ill;
        decode_fetch_fault = ff;
        decode_instruction = instr;
        decode_pc          = pc;
        decode_id          = id;
    endtask

    task automatic idle_decode();
        decode_valid       = 1'b0;
        decode_illegal     = 1'b0;
        decode_fetch_fault = 1'b0;
    endtask

    // One complete illegal exception: capture, drain, request, ack, flush.
    task automatic full_illegal_event();
        present(1'b1, 1'b0, 32'h0000_0000, 32'h0000_4000, 3'd1);
        tick();
        idle_decode();
        tick();
        exception_ack = 1'b1;
        tick();
        exception_ack = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle_decode();
        decode_instruction = '0;
        decode_pc          = '0;
        decode_id          = '0;
        pipeline_empty     = 1'b1;
        flush              = 1'b0;
        exception_ack      = 1'b0;
        #12;
        chk("rst_issue_block", 32'(issue_block), 32'd0);
        chk("rst_valid", 32'(exception_valid), 32'd0);
        chk("rst_code", 32'(exception_code), 32'd0);
        chk("rst_pc", exception_pc, 32'd0);
        chk("rst_tval", exception_tval, 32'd0);
        chk("rst_id", 32'(exception_id), 32'd0);
        chk("rst_count", 32'(illegal_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Illegal instruction with an already-empty pipeline
        present(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0010, 3'd5);
        #1;
        chk("t1_block_same_cycle", 32'(issue_block), 32'd1);
        chk("t1_valid_at_trigger", 32'(exception_valid), 32'd0);
        tick();
        idle_decode();
        chk("t1_valid_in_drain", 32'(exception_valid), 32'd0);
        chk("t1_block_in_drain", 32'(issue_block), 32'd1);
        tick();
        chk("t1_valid", 32'(exception_valid), 32'd1);
        chk("t1_code", 32'(exception_code), 32'd2);
        chk("t1_tval", exception_tval, 32'hFFFF_FFFF);
        chk("t1_pc", exception_pc, 32'h8000_0010);
        chk("t1_id", 32'(exception_id), 32'd5);
        exception_ack = 1'b1;
        tick();
        exception_ack = 1'b0;
        chk("t1_valid_wait_flush", 32'(exception_valid), 32'd0);
        chk("t1_block_wait_flush", 32'(issue_block), 32'd1);
        chk("t1_count", 32'(illegal_count), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t1_block_after_flush", 32'(issue_block), 32'd0);

        // Fetch fault together with illegal: fetch fault wins
        present(1'b1, 1'b1, 32'h1234_5678, 32'h0000_1000, 3'd2);
        tick();
        idle_decode();
        tick();
        chk("t2_valid", 32'(exception_valid), 32'd1);
        chk("t2_code", 32'(exception_code), 32'd12);
        chk("t2_tval", exception_tval, 32'h0000_1000);
        exception_ack = 1'b1;
        tick();
        exception_ack = 1'b0;
        chk("t2_count_unchanged", 32'(illegal_count), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Drain hold, ignored decode changes, held request, ack+flush race
        pipeline_empty = 1'b0;
        present(1'b1, 1'b0, 32'hDEAD_0000, 32'h0000_2000, 3'd3);
        tick();
        present(1'b1, 1'b1, 32'h5555_5555, 32'h0000_9999, 3'd6);
        for (int i = 0; i < 6; i++) begin
            chk("t3_valid_drain_hold", 32'(exception_valid), 32'd0);
            tick();
        end
        chk("t3_valid_drain_last", 32'(exception_valid), 32'd0);
        pipeline_empty = 1'b1;
        tick();
        chk("t3_valid_after_empty", 32'(exception_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_valid_held", 32'(exception_valid), 32'd1);
            chk("t3_pc_held", exception_pc, 32'h0000_2000);
            chk("t3_tval_held", exception_tval, 32'hDEAD_0000);
            chk("t3_id_held", 32'(exception_id), 32'd3);
            chk("t3_code_held", 32'(exception_code), 32'd2);
        end
        idle_decode();
        exception_ack = 1'b1;
        flush = 1'b1;
        tick();
        exception_ack = 1'b0;
        flush = 1'b0;
        chk("t3_race_valid", 32'(exception_valid), 32'd0);
        chk("t3_race_block", 32'(issue_block), 32'd1);
        chk("t3_race_count", 32'(illegal_count), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_idle_block", 32'(issue_block), 32'd0);

        // Flush during DRAIN: no request
        pipeline_empty = 1'b0;
        present(1'b1, 1'b0, 32'h0000_0001, 32'h0000_3000, 3'd4);
        tick();
        idle_decode();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pipeline_empty = 1'b1;
        chk("t4_drain_flush_block", 32'(issue_block), 32'd0);
        tick();
        chk("t4_drain_flush_valid", 32'(exception_valid), 32'd0);

        // Flush during REQUEST without ack: withdrawn, not counted
        present(1'b1, 1'b0, 32'h0000_0002, 32'h0000_3004, 3'd7);
        tick();
        idle_decode();
        tick();
        chk("t5_valid", 32'(exception_valid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_withdrawn", 32'(exception_valid), 32'd0);
        chk("t5_block", 32'(issue_block), 32'd0);
        chk("t5_count", 32'(illegal_count), 32'd2);

        // Saturation: count is 2, 13 more events reach 15, 2 more must hold 15
        for (int i = 0; i < 13; i++) full_illegal_event();
        chk("sat_reach", 32'(illegal_count), 32'd15);
        for (int i = 0; i < 2; i++) full_illegal_event();
        chk("sat_hold", 32'(illegal_count), 32'd15);

        // Asynchronous reset in the middle of REQUEST
        present(1'b1, 1'b0, 32'hCAFE_F00D, 32'h0000_5000, 3'd2);
        tick();
        idle_decode();
        tick();
        chk("t6_valid_before_rst", 32'(exception_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(exception_valid), 32'd0);
        chk("t6_rst_block", 32'(issue_block), 32'd0);
        chk("t6_rst_count", 32'(illegal_count), 32'd0);
        chk("t6_rst_pc", exception_pc, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("t6_post_rst_idle", 32'(exception_valid), 32'd0);
        present(1'b1, 1'b0, 32'h0BAD_0BAD, 32'h0000_6000, 3'd6);
        tick();
        idle_decode();
        tick();
        chk("t6_post_valid", 32'(exception_valid), 32'd1);
        chk("t6_post_tval", exception_tval, 32'h0BAD_0BAD);
        exception_ack = 1'b1;
        tick();
        exception_ack = 1'b0;
        chk("t6_post_count", 32'(illegal_count), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
